// File: rtl/dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : dmem_arbiter
// Description : Round-robin arbiter that shares the single-port data memory
//               between the CPU memory stage and the debug/loader port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [0:0] c_OWN_CPU = 1'b0;
  localparam logic [0:0] c_OWN_DBG = 1'b1;

  logic [0:0] r_last_win;
  logic       r_locked;
  logic       r_rd_valid;
  logic [0:0] r_rd_owner;

  logic       w_cpu_elig;
  logic       w_dbg_elig;
  logic       w_cpu_win;
  logic       w_dbg_win;
  logic       w_any_gnt;
  logic       w_win_we;
  logic [0:0] w_winner;

  // A held lock removes the CPU from contention entirely.
  always_comb begin
    w_cpu_elig = cpu_req & ~r_locked & ~reset;
    w_dbg_elig = dbg_req & ~reset;
    w_cpu_win  = 1'b0;
    w_dbg_win  = 1'b0;
    if (w_cpu_elig && w_dbg_elig) begin
      w_dbg_win = (r_last_win == c_OWN_CPU);
      w_cpu_win = ~w_dbg_win;
    end else begin
      w_cpu_win = w_cpu_elig;
      w_dbg_win = w_dbg_elig;
    end
  end

  assign w_any_gnt = w_cpu_win | w_dbg_win;
  assign w_winner  = w_dbg_win ? c_OWN_DBG : c_OWN_CPU;
  assign w_win_we  = w_dbg_win ? dbg_we : cpu_we;

  assign cpu_gnt     = w_cpu_win;
  assign dbg_gnt     = w_dbg_win;
  assign mem_address = w_dbg_win ? dbg_addr : cpu_addr;
  assign mem_data    = w_dbg_win ? dbg_wdata : cpu_wdata;
  assign mem_wren    = w_any_gnt & w_win_we;

  assign cpu_rvalid = r_rd_valid & (r_rd_owner == c_OWN_CPU) & ~reset;
  assign dbg_rvalid = r_rd_valid & (r_rd_owner == c_OWN_DBG) & ~reset;
  assign cpu_rdata  = cpu_rvalid ? mem_q : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_q : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_win <= c_OWN_DBG;
      r_locked   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_owner <= c_OWN_CPU;
    end else begin
      if (w_any_gnt) begin
        r_last_win <= w_winner;
        r_rd_valid <= ~w_win_we;
        r_rd_owner <= w_winner;
      end else begin
        r_rd_valid <= 1'b0;
      end
      // An idle debug port gives up any lock it was holding.
      if (w_dbg_win) begin
        r_locked <= dbg_lock;
      end else if (!w_any_gnt && !dbg_req) begin
        r_locked <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a behavioural RAM.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic [9:0]  mem_address;
  logic [31:0] mem_data, mem_q;
  logic        mem_wren;
  logic        ram_init;
  logic [31:0] ram [1024];

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  // Single-port RAM with read-before-write output register
  always @(posedge clock) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
    end else begin
      if (mem_wren) ram[mem_address] <= mem_data;
      mem_q <= ram[mem_address];
    end
  end

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          m_last_dbg;
  bit          m_locked;
  bit          m_pend_v;
  bit          m_pend_dbg;
  bit [31:0]   m_pend_data;
  bit [31:0]   m_mem [1024];

  logic        s_cg, s_dg, s_wr, s_cv, s_dv;
  logic [31:0] s_rd;

  typedef struct {
    bit rst; bit creq; bit cwe; bit [9:0] caddr; bit [31:0] cwd;
    bit dreq; bit dwe; bit dlock; bit [9:0] daddr; bit [31:0] dwd;
    bit ecg; bit edg; bit ewr; bit ecv; bit edv; bit [31:0] erd;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(bit rst, bit creq, bit cwe, bit [9:0] caddr, bit [31:0] cwd,
                              bit dreq, bit dwe, bit dlock, bit [9:0] daddr, bit [31:0] dwd,
                              bit ecg, bit edg, bit ewr, bit ecv, bit edv, bit [31:0] erd);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.dlock = dlock; v.daddr = daddr; v.dwd = dwd;
    v.ecg = ecg; v.edg = edg; v.ewr = ewr; v.ecv = ecv; v.edv = edv; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs already driven; check against the model, then advance it.
  task automatic tick();
    bit ce, de, cw, dw, ewr, cv, dv, win_we;
    bit [9:0]  ea;
    bit [31:0] ed;
    #1;
    cw = 0; dw = 0;
    if (!reset) begin
      ce = cpu_req && !m_locked;
      de = dbg_req;
      if (ce && de) begin
        dw = !m_last_dbg;
        cw = !dw;
      end else begin
        cw = ce;
        dw = de;
      end
    end
    win_we = dw ? dbg_we : cpu_we;
    ewr = (cw || dw) && win_we;
    ea  = dw ? dbg_addr : cpu_addr;
    ed  = dw ? dbg_wdata : cpu_wdata;
    cv  = !reset && m_pend_v && !m_pend_dbg;
    dv  = !reset && m_pend_v && m_pend_dbg;
    chk("model cpu_gnt", 32'(cpu_gnt), 32'(cw));
    chk("model dbg_gnt", 32'(dbg_gnt), 32'(dw));
    chk("model mem_wren", 32'(mem_wren), 32'(ewr));
    chk("model mem_address", 32'(mem_address), 32'(ea));
    chk("model mem_data", mem_data, ed);
    chk("model cpu_rvalid", 32'(cpu_rvalid), 32'(cv));
    chk("model dbg_rvalid", 32'(dbg_rvalid), 32'(dv));
    chk("model cpu_rdata", cpu_rdata, cv ? m_pend_data : 32'h0);
    chk("model dbg_rdata", dbg_rdata, dv ? m_pend_data : 32'h0);
    s_cg = cpu_gnt; s_dg = dbg_gnt; s_wr = mem_wren; s_cv = cpu_rvalid; s_dv = dbg_rvalid;
    s_rd = cpu_rdata | dbg_rdata;
    @(posedge clock);
    if (reset) begin
      m_last_dbg = 1; m_locked = 0; m_pend_v = 0;
    end else begin
      if (cw || dw) begin
        m_last_dbg  = dw;
        m_pend_v    = !win_we;
        m_pend_dbg  = dw;
        m_pend_data = m_mem[ea];
        if (ewr) m_mem[ea] = ed;
      end else begin
        m_pend_v = 0;
      end
      if (dw) m_locked = dbg_lock;
      else if (!cw && !dbg_req) m_locked = 0;
    end
    @(negedge clock);
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    dbg_req = v.dreq; dbg_we = v.dwe; dbg_lock = v.dlock; dbg_addr = v.daddr; dbg_wdata = v.dwd;
  endtask

  initial begin
    // Directed sequences: reset/write/read, alternation, lock, abandon, reset mid-read, idle
    tbl.push_back(mk(1,1,1,5,32'hDEADBEEF, 0,0,0,0,0,       0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,5,32'hDEADBEEF, 0,0,0,0,0,       1,0,1,0,0,0));
    tbl.push_back(mk(0,1,0,5,0,            0,0,0,0,0,       1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            0,0,0,0,0,       0,0,0,1,0,32'hDEADBEEF));
    tbl.push_back(mk(0,0,0,0,0,            1,1,0,1,32'h11,  0,1,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,1,0,2,32'h22,  0,1,1,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,            1,0,0,2,0,       1,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,            1,0,0,2,0,       0,1,0,1,0,32'h11));
    tbl.push_back(mk(0,1,0,1,0,            1,0,0,2,0,       1,0,0,0,1,32'h22));
    tbl.push_back(mk(0,1,0,1,0,            1,0,0,2,0,       0,1,0,1,0,32'h11));
    tbl.push_back(mk(0,1,0,3,0,            0,0,0,0,0,       1,0,0,0,1,32'h22));
    tbl.push_back(mk(0,1,0,1,0,            1,0,1,7,0,       0,1,0,1,0,0));
    tbl.push_back(mk(0,1,0,1,0,            1,1,0,7,32'h77,  0,1,1,0,1,0));
    tbl.push_back(mk(0,1,0,1,0,            0,0,0,0,0,       1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            0,0,0,0,0,       0,0,0,1,0,32'h11));
    tbl.push_back(mk(0,1,0,1,0,            1,0,1,8,0,       0,1,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,            0,0,0,0,0,       0,0,0,0,1,0));
    tbl.push_back(mk(0,1,0,1,0,            0,0,0,0,0,       1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            0,0,0,0,0,       0,0,0,1,0,32'h11));
    tbl.push_back(mk(0,1,0,5,0,            0,0,0,0,0,       1,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,            0,0,0,0,0,       0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,            1,0,0,2,0,       1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            0,0,0,0,0,       0,0,0,1,0,32'h11));
    tbl.push_back(mk(0,0,0,0,0,            0,0,0,0,0,       0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            0,0,0,0,0,       0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            0,0,0,0,0,       0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,7,0,            0,0,0,0,0,       1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,1,0,7,32'h99,  0,1,1,1,0,32'h77));
    tbl.push_back(mk(0,0,0,0,0,            0,0,0,0,0,       0,0,0,0,0,0));

    for (int i = 0; i < 1024; i++) m_mem[i] = '0;
    m_last_dbg = 1; m_locked = 0; m_pend_v = 0; m_pend_dbg = 0; m_pend_data = '0;
    ram_init = 1'b1;
    apply(tbl[0]);
    @(posedge clock);
    @(negedge clock);
    ram_init = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      tick();
      chk($sformatf("row%0d cpu_gnt", i), 32'(s_cg), 32'(tbl[i].ecg));
      chk($sformatf("row%0d dbg_gnt", i), 32'(s_dg), 32'(tbl[i].edg));
      chk($sformatf("row%0d mem_wren", i), 32'(s_wr), 32'(tbl[i].ewr));
      chk($sformatf("row%0d cpu_rvalid", i), 32'(s_cv), 32'(tbl[i].ecv));
      chk($sformatf("row%0d dbg_rvalid", i), 32'(s_dv), 32'(tbl[i].edv));
      chk($sformatf("row%0d rdata", i), s_rd, tbl[i].erd);
      if (i == 25) begin
        chk("idle ram[1]", ram[1], 32'h11);
        chk("idle ram[2]", ram[2], 32'h22);
        chk("idle ram[5]", ram[5], 32'hDEADBEEF);
        chk("idle ram[7]", ram[7], 32'h77);
      end
    end
    chk("rbw ram[7]", ram[7], 32'h99);

    // Randomised traffic over a small address window to force collisions
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 63) == 0);
      cpu_req   = ($urandom_range(0, 9) < 7);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = 10'($urandom_range(0, 15));
      cpu_wdata = $urandom;
      dbg_req   = ($urandom_range(0, 9) < 6);
      dbg_we    = $urandom_range(0, 1) == 1;
      dbg_lock  = ($urandom_range(0, 3) == 0);
      dbg_addr  = 10'($urandom_range(0, 15));
      dbg_wdata = $urandom;
      tick();
    end
    for (int a = 0; a < 16; a++) chk($sformatf("final ram[%0d]", a), ram[a], m_mem[a]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
